// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//   This block is the program-counter sequencer of a simple multi-cycle core.
//   It fetches an instruction at PC and waits for instruction memory. It then
//   latches the word into IR and holds in EXEC until the datapath retires it.
//   On retirement it advances PC by one of three rules: sequential (PC+4),
//   taken branch (PC+4 + imm*4) or jump (region of PC+4 plus the 26-bit
//   target). When it fetches the HALT_WORD encoding it parks in HALT, and only
//   reset can release it.
//
// Parameters:
//   RESET_PC    PC value loaded on reset
//   HALT_WORD   instruction encoding that stops sequencing
//
// Ports:
//   CLK          in   1   system clock, rising-edge active
//   reset        in   1   asynchronous active-low reset
//   imem_ready   in   1   Instr is valid this cycle
//   Instr        in  32   instruction word from instruction memory
//   Jump         in   1   decoded jump for IR (used in EXEC only)
//   Branch       in   1   decoded conditional branch for IR (EXEC only)
//   Bzero        in   1   ALU zero flag (EXEC only)
//   imm          in  32   sign-extended word offset (EXEC only)
//   stall        in   1   datapath not ready to retire; holds EXEC
//   imem_req     out  1   fetch request at address PC
//   PC           out 32   program counter (registered)
//   IR           out 32   latched instruction (registered)
//   instr_valid  out  1   IR holds an instruction being executed
//   PC_src       out  2   next-PC source: 00 PC+4, 01 branch, 10 jump, 11 hold
//   state        out  2   00 FETCH, 01 WAIT, 10 EXEC, 11 HALT
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic [31:0] Instr,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Bzero,
    input  logic [31:0] imm,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] PC,
    output logic [31:0] IR,
    output logic        instr_valid,
    output logic [1:0]  PC_src,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_WAIT  = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        SRC_SEQ    = 2'b00,
        SRC_BRANCH = 2'b01,
        SRC_JUMP   = 2'b10,
        SRC_HOLD   = 2'b11
    } pc_src_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;

    logic [31:0] pc4;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    pc_src_e     pc_src_sel;

    // Target arithmetic is modulo 2^32; any carry out of bit 31 is dropped.
    assign pc4           = pc_q + 32'd4;
    assign jump_target   = {pc4[31:28], ir_q[25:0], 2'b00};
    assign branch_target = pc4 + (imm << 2);

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        pc_src_sel  = SRC_HOLD;

        case (state_q)
            ST_FETCH, ST_WAIT: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_d    = Instr;
                    state_d = (Instr == HALT_WORD) ? ST_HALT : ST_EXEC;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    // Jump takes priority over a branch on the same instruction.
                    if (Jump) begin
                        pc_src_sel = SRC_JUMP;
                        pc_d       = jump_target;
                    end else if (Branch && Bzero) begin
                        pc_src_sel = SRC_BRANCH;
                        pc_d       = branch_target;
                    end else begin
                        pc_src_sel = SRC_SEQ;
                        pc_d       = pc4;
                    end
                    state_d = ST_FETCH;
                end
            end

            default: begin
                // HALT: PC and IR stay frozen until reset.
                state_d = ST_HALT;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples the pre-edge value of every other flop, whatever the process
    // order in simulation.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // The outputs are decoded from the registered state. While reset holds
    // state at FETCH, they sit at their reset values without a separate path.
    assign PC     = pc_q;
    assign IR     = ir_q;
    assign PC_src = pc_src_sel;
    assign state  = state_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, the instruction encoding that stops sequencing.
REQ-003 Port CLK  input  1: single system clock; all state changes on the rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port imem_ready  input  1: instruction memory has valid data on Instr this cycle.
REQ-006 Port Instr  input  32: instruction word from instruction memory.
REQ-007 Port Jump  input  1: decoded jump for the instruction in IR, sampled in EXEC only.
REQ-008 Port Branch  input  1: decoded conditional branch for the instruction in IR, sampled in EXEC only.
REQ-009 Port Bzero  input  1: ALU zero flag, sampled in EXEC only.
REQ-010 Port imm  input  32: sign-extended immediate (word offset), sampled in EXEC only.
REQ-011 Port stall  input  1: datapath not ready to retire; holds EXEC.
REQ-012 Port imem_req  output  1: fetch request to instruction memory at address PC.
REQ-013 Port PC  output  32: current program counter (registered).
REQ-014 Port IR  output  32: latched instruction (registered).
REQ-015 Port instr_valid  output  1: IR holds an instruction being executed.
REQ-016 Port PC_src  output  2: next-PC source selected this cycle: 00 PC+4, 01 branch, 10 jump, 11 hold.
REQ-017 Port state  output  2: FSM state: 00 FETCH, 01 WAIT, 10 EXEC, 11 HALT.

Function
REQ-018 FETCH: imem_req=1; if imem_ready=1, IR<=Instr and next state EXEC; else next state WAIT.
REQ-019 WAIT: imem_req=1; stay until imem_ready=1, then IR<=Instr, next state EXEC; PC unchanged throughout.
REQ-020 In FETCH/WAIT, if the captured Instr equals HALT_WORD, next state SHALL be HALT instead of EXEC (IR still updated).
REQ-021 EXEC: instr_valid=1, imem_req=0; if stall=1 stay in EXEC with PC and IR held, PC_src=11.
REQ-022 EXEC with stall=0: PC<=next PC, next state FETCH (one retire per EXEC exit).
REQ-023 pc4 = PC + 4 modulo 2^32 (wrap-around, no carry out).
REQ-024 Jump=1: next PC = {pc4[31:28], IR[25:0], 2'b00}, PC_src=10; Jump SHALL have priority over Branch.
REQ-025 Branch=1 and Bzero=1 (Jump=0): next PC = pc4 + (imm << 2) modulo 2^32, PC_src=01.
REQ-026 Otherwise (incl. Branch=1, Bzero=0): next PC = pc4, PC_src=00.
REQ-027 PC_src SHALL be 11 in FETCH, WAIT and HALT.
REQ-028 HALT: imem_req=0, instr_valid=0, PC and IR frozen; exit only via reset.
REQ-029 Jump/Branch/Bzero/imm SHALL be ignored outside EXEC.
REQ-030 Minimum instruction latency: 2 cycles (FETCH with imem_ready=1, then EXEC with stall=0).

Reset
REQ-031 reset=0 SHALL immediately (asynchronously) force state=FETCH, PC=RESET_PC, IR=0, instr_valid=0, imem_req=1, PC_src=11.
REQ-032 Reset asserted mid-WAIT or mid-EXEC SHALL abandon the in-flight instruction with no PC update; first fetch after release is at RESET_PC.
REQ-033 Outputs SHALL remain at reset values while reset=0, regardless of other inputs.

Verification
REQ-034 Sequential: imem_ready=1, stall=0, Instr=32'h12345678, Jump=Branch=0 -> PC 0x0, 0x4, 0x8 every 2 cycles, PC_src=00 in EXEC.
REQ-035 Jump: PC=0x0, Instr=32'h08000010, Jump=1 in EXEC -> PC=0x00000040, PC_src=10; Branch=1 also set gives same result.
REQ-036 Branch: PC=0x40, Branch=1, Bzero=1, imm=32'h00000003 -> PC=0x50; imm=32'hFFFFFFFF -> PC=0x40; Bzero=0 -> PC=0x44.
REQ-037 Handshake/stall: imem_ready low 3 cycles -> state WAIT 3 cycles, PC held; stall=1 for 2 EXEC cycles -> instr_valid high 3 cycles, single PC update.
REQ-038 Wrap/halt: RESET_PC=32'hFFFFFFFC sequential -> next PC=0x00000000; Instr=32'hFFFFFFFF -> state HALT, imem_req=0, PC frozen.
REQ-039 Async reset: drop reset between clock edges during EXEC -> PC=RESET_PC, state=FETCH before next edge.
